serial_tx10: RTL and testbench

- Transmitter that takes one 10-bit parallel word per valid/ready handshake and shifts it out on a single serial line with start/stop framing and optional parity.
- Acts as the far end of the team's 10-bit parallel register path: a register holds the word, and this block serializes it for the companion receiver.
- All outputs are registered; one clock domain.

---
 rtl/serial_tx10.sv | 165 ++++++++++++++++
 tb/tb_serial_tx10.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx10.sv
// Serial transmitter: one 10-bit word per valid/ready handshake, framed as
// start bit, ten data bits LSB first, optional even parity, and a stop bit.
module serial_tx10 #(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

  function automatic logic even_parity(input logic [9:0] word);
    return ^word;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] baud_q, baud_d;
  logic [3:0] bit_q, bit_d;
  logic [9:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic       tx_out_q, tx_out_d;
  logic       tx_ready_q, tx_ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       bit_end_s;

  assign tx_ready = tx_ready_q;
  assign tx_out   = tx_out_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // tx_out_d is the line level for the coming cycle, so the output stays a flop
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tx_out_d   = tx_out_q;
    tx_ready_d = tx_ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bit_end_s  = (baud_q == BAUD_LAST);

    case (state_q)
      IDLE: begin
        tx_out_d   = 1'b1;
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
        if (tx_valid && tx_ready_q) begin
          shift_d    = tx_data;
          parity_d   = even_parity(tx_data);
          baud_d     = 8'd0;
          bit_d      = 4'd0;
          state_d    = START;
          tx_out_d   = 1'b0;
          tx_ready_d = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          baud_d   = 8'd0;
          state_d  = DATA;
          tx_out_d = shift_q[0];
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          baud_d  = 8'd0;
          shift_d = {1'b0, shift_q[9:1]};
          if (bit_q == 4'd9) begin
            bit_d = 4'd0;
            if (PARITY_EN != 0) begin
              state_d  = PARITY;
              tx_out_d = parity_q;
            end else begin
              state_d  = STOP;
              tx_out_d = 1'b1;
            end
          end else begin
            bit_d    = bit_q + 4'd1;
            tx_out_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          baud_d   = 8'd0;
          state_d  = STOP;
          tx_out_d = 1'b1;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      STOP: begin
        tx_out_d = 1'b1;
        if (bit_end_s) begin
          baud_d     = 8'd0;
          state_d    = IDLE;
          tx_ready_d = 1'b1;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        baud_d     = 8'd0;
        bit_d      = 4'd0;
        tx_out_d   = 1'b1;
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  // Reset aborts any frame without a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= 8'd0;
      bit_q      <= 4'd0;
      shift_q    <= 10'd0;
      parity_q   <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_out_q   <= tx_out_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_tx10.sv
// Directed bench for serial_tx10: instance a uses 4 clocks/bit without parity,
// instance b uses 1 clock/bit with parity. Outputs are sampled 1ns after posedge.
module tb_serial_tx10;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ready_a, out_a, busy_a, done_a;
  logic       ready_b, out_b, busy_b, done_b;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  serial_tx10 #(.CLKS_PER_BIT(4), .PARITY_EN(0)) dut_a (
    .clk(clk), .rst(rst), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .tx_out(out_a), .busy(busy_a), .done(done_a)
  );

  serial_tx10 #(.CLKS_PER_BIT(1), .PARITY_EN(1)) dut_b (
    .clk(clk), .rst(rst), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .tx_out(out_b), .busy(busy_b), .done(done_b)
  );

  task automatic test_reset();
    rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; data_a = 10'd0; data_b = 10'd0;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({out_a, ready_a, busy_a, done_a} !== 4'b1100) begin
        errors++;
        $display("FAIL reset_a cycle %0d: out/ready/busy/done=%b expected 1100", c, {out_a, ready_a, busy_a, done_a});
      end
      checks++;
      if ({out_b, ready_b, busy_b, done_b} !== 4'b1100) begin
        errors++;
        $display("FAIL reset_b cycle %0d: out/ready/busy/done=%b expected 1100", c, {out_b, ready_b, busy_b, done_b});
      end
    end
  endtask

  task automatic test_frame_c4();
    logic [0:11] exp_line;
    exp_line = 12'b0_1010010101_1;
    valid_a = 1'b1; data_a = 10'h2A5;
    @(posedge clk); #1;
    valid_a = 1'b0; data_a = 10'h000;
    for (int k = 0; k < 48; k++) begin
      checks++;
      if ({out_a, ready_a, busy_a, done_a} !== {exp_line[k/4], 3'b010}) begin
        errors++;
        $display("FAIL frame_c4 k=%0d: out/ready/busy/done=%b expected %b", k, {out_a, ready_a, busy_a, done_a}, {exp_line[k/4], 3'b010});
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({out_a, ready_a, busy_a, done_a} !== 4'b1101) begin
      errors++;
      $display("FAIL frame_c4_done k=48: out/ready/busy/done=%b expected 1101", {out_a, ready_a, busy_a, done_a});
    end
    @(posedge clk); #1;
    checks++;
    if ({out_a, ready_a, busy_a, done_a} !== 4'b1100) begin
      errors++;
      $display("FAIL frame_c4_after k=49: out/ready/busy/done=%b expected 1100", {out_a, ready_a, busy_a, done_a});
    end
  endtask

  task automatic test_parity_c1();
    logic [0:12] exp_line;
    exp_line = 13'b0_1110000000_1_1;
    valid_b = 1'b1; data_b = 10'h007;
    @(posedge clk); #1;
    valid_b = 1'b0; data_b = 10'h3FF;
    for (int k = 0; k < 13; k++) begin
      checks++;
      if ({out_b, ready_b, busy_b, done_b} !== {exp_line[k], 3'b010}) begin
        errors++;
        $display("FAIL parity_c1 k=%0d: out/ready/busy/done=%b expected %b", k, {out_b, ready_b, busy_b, done_b}, {exp_line[k], 3'b010});
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({out_b, ready_b, busy_b, done_b} !== 4'b1101) begin
      errors++;
      $display("FAIL parity_c1_done k=13: out/ready/busy/done=%b expected 1101", {out_b, ready_b, busy_b, done_b});
    end
  endtask

  task automatic test_back_to_back();
    logic exp_bit;
    valid_a = 1'b1; data_a = 10'h3FF;
    @(posedge clk); #1;
    data_a = 10'h000;
    for (int k = 0; k < 48; k++) begin
      exp_bit = (k >= 4);
      checks++;
      if ({out_a, ready_a, done_a} !== {exp_bit, 2'b00}) begin
        errors++;
        $display("FAIL b2b_first k=%0d: out/ready/done=%b expected %b", k, {out_a, ready_a, done_a}, {exp_bit, 2'b00});
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({out_a, ready_a, busy_a, done_a} !== 4'b1101) begin
      errors++;
      $display("FAIL b2b_gap: out/ready/busy/done=%b expected 1101", {out_a, ready_a, busy_a, done_a});
    end
    @(posedge clk); #1;
    for (int k = 0; k < 48; k++) begin
      if (k == 1) begin
        valid_a = 1'b0; data_a = 10'h3FF;
      end
      exp_bit = (k >= 44);
      checks++;
      if ({out_a, ready_a, busy_a, done_a} !== {exp_bit, 3'b010}) begin
        errors++;
        $display("FAIL b2b_second k=%0d: out/ready/busy/done=%b expected %b", k, {out_a, ready_a, busy_a, done_a}, {exp_bit, 3'b010});
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({out_a, ready_a, busy_a, done_a} !== 4'b1101) begin
      errors++;
      $display("FAIL b2b_second_done: out/ready/busy/done=%b expected 1101", {out_a, ready_a, busy_a, done_a});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_frame();
    logic [0:11] exp_line;
    exp_line = 12'b0_0000111100_1;
    valid_a = 1'b1; data_a = 10'h1DF;
    @(posedge clk); #1;
    valid_a = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
    end
    checks++;
    if (out_a !== 1'b0) begin
      errors++;
      $display("FAIL midrst_bit5: out=%b expected 0", out_a);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({out_a, ready_a, busy_a, done_a} !== 4'b1100) begin
      errors++;
      $display("FAIL midrst_abort: out/ready/busy/done=%b expected 1100", {out_a, ready_a, busy_a, done_a});
    end
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_a, done_a} !== 2'b10) begin
        errors++;
        $display("FAIL midrst_quiet c=%0d: out/done=%b expected 10", c, {out_a, done_a});
      end
    end
    valid_a = 1'b1; data_a = 10'h0F0;
    @(posedge clk); #1;
    valid_a = 1'b0;
    for (int k = 0; k < 48; k++) begin
      checks++;
      if ({out_a, done_a} !== {exp_line[k/4], 1'b0}) begin
        errors++;
        $display("FAIL midrst_resend k=%0d: out/done=%b expected %b", k, {out_a, done_a}, {exp_line[k/4], 1'b0});
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({out_a, ready_a, done_a} !== 3'b111) begin
      errors++;
      $display("FAIL midrst_resend_done: out/ready/done=%b expected 111", {out_a, ready_a, done_a});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_with_valid();
    int n;
    valid_a = 1'b1; data_a = 10'h001; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({out_a, ready_a, busy_a, done_a} !== 4'b1100) begin
      errors++;
      $display("FAIL rst_valid_hold: out/ready/busy/done=%b expected 1100", {out_a, ready_a, busy_a, done_a});
    end
    @(posedge clk); #1;
    valid_a = 1'b0;
    checks++;
    if ({out_a, ready_a, busy_a} !== 3'b001) begin
      errors++;
      $display("FAIL rst_valid_accept: out/ready/busy=%b expected 001", {out_a, ready_a, busy_a});
    end
    n = 0;
    while (done_a !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 48) begin
      errors++;
      $display("FAIL rst_valid_done_latency: done after %0d cycles expected 48", n);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_frame_c4();
    test_parity_c1();
    test_back_to_back();
    test_reset_mid_frame();
    test_reset_with_valid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
